// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// timer_pkg : register map, TCR/TSR field indices, Cks encodings (TIMER_AUTO_RELOAD_EN) | rev 1.0
// ============================================================================
package timer_pkg;

  localparam logic [1:0] TDR_OFS  = 2'd0;
  localparam logic [1:0] TCR_OFS  = 2'd1;
  localparam logic [1:0] TSR_OFS  = 2'd2;
  localparam logic [1:0] TCNT_OFS = 2'd3;

  localparam int LOAD   = 7;
  localparam int ARE    = 6;
  localparam int UPDW   = 5;
  localparam int EN     = 4;
  localparam int CKS_HI = 1;
  localparam int CKS_LO = 0;

  localparam int OVF = 0;
  localparam int UDF = 1;

`ifdef TIMER_AUTO_RELOAD_EN
  localparam int ARE_EN = 1;
`else
  localparam int ARE_EN = 0;
`endif

  // Implemented TCR bits; everything else reads back as zero.
  localparam logic [7:0] TCR_MASK = 8'((1 << LOAD) | (ARE_EN << ARE) | (1 << UPDW) |
                                       (1 << EN) | ((1 << (CKS_HI + 1)) - (1 << CKS_LO)));

  typedef enum logic [1:0] {
    CKS_DIV2  = 2'b00,
    CKS_DIV4  = 2'b01,
    CKS_DIV8  = 2'b10,
    CKS_DIV16 = 2'b11
  } cks_e;

  function automatic logic prescale_tap(input logic [3:0] pre, input cks_e cks);
    logic tap;
    case (cks)
      CKS_DIV2:  tap = pre[0];
      CKS_DIV4:  tap = pre[1];
      CKS_DIV8:  tap = pre[2];
      default:   tap = pre[3];
    endcase
    return tap;
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_channel.sv
`default_nettype none
// ============================================================================
// timer_channel : one TDR/TCR/TSR/TCNT timer channel (TIMER_AUTO_RELOAD_EN) | rev 1.0
// ============================================================================
module timer_channel
  import timer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            i_pre,
  input  logic                  i_wr_tdr,
  input  logic                  i_wr_tcr,
  input  logic                  i_wr_tsr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_tdr,
  output logic [DATA_WIDTH-1:0] o_tcr,
  output logic [DATA_WIDTH-1:0] o_tsr,
  output logic [DATA_WIDTH-1:0] o_tcnt,
  output logic                  o_ovf,
  output logic                  o_udf
);

  localparam logic [DATA_WIDTH-1:0] C_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] C_ONE  = DATA_WIDTH'(1);

  logic [DATA_WIDTH-1:0] tdr_q, tdr_d;
  logic [DATA_WIDTH-1:0] tcnt_q, tcnt_d;
  logic [7:0]            tcr_q, tcr_d;
  logic [1:0]            tsr_q, tsr_d;
  logic                  tcr7_q, tcr7_d;
  logic                  tap_q, tap_d;

  logic w_tap;
  logic w_load;
  logic w_tick;
  logic w_reload;
  logic w_ovf_set;
  logic w_udf_set;

  always_comb begin
    tdr_d     = tdr_q;
    tcr_d     = tcr_q;
    tsr_d     = tsr_q;
    tcnt_d    = tcnt_q;
    w_ovf_set = 1'b0;
    w_udf_set = 1'b0;

    if (i_wr_tdr) tdr_d = i_wdata;
    if (i_wr_tcr) tcr_d = i_wdata[7:0] & TCR_MASK;

    w_tap  = prescale_tap(i_pre, cks_e'(tcr_q[CKS_HI:CKS_LO]));
    tap_d  = w_tap;
    tcr7_d = tcr_q[LOAD];
    w_load = tcr_q[LOAD] & ~tcr7_q;
    w_tick = w_tap & ~tap_q;

`ifdef TIMER_AUTO_RELOAD_EN
    w_reload = tcr_q[ARE];
`else
    w_reload = 1'b0;
`endif

    // Load wins over a coincident tick.
    if (w_load) begin
      tcnt_d = tdr_q;
    end else if (w_tick && tcr_q[EN]) begin
      if (!tcr_q[UPDW]) begin
        if (tcnt_q == C_ONES) begin
          w_ovf_set = 1'b1;
          tcnt_d    = w_reload ? tdr_q : '0;
        end else begin
          tcnt_d = tcnt_q + C_ONE;
        end
      end else begin
        if (tcnt_q == '0) begin
          w_udf_set = 1'b1;
          tcnt_d    = w_reload ? tdr_q : C_ONES;
        end else begin
          tcnt_d = tcnt_q - C_ONE;
        end
      end
    end

    // Hardware set is applied after the W1C so a same-cycle event is never lost.
    if (i_wr_tsr) tsr_d = tsr_q & ~i_wdata[1:0];
    tsr_d[OVF] = tsr_d[OVF] | w_ovf_set;
    tsr_d[UDF] = tsr_d[UDF] | w_udf_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tdr_q  <= '0;
      tcr_q  <= '0;
      tsr_q  <= '0;
      tcnt_q <= '0;
      tcr7_q <= 1'b0;
      tap_q  <= 1'b0;
    end else begin
      tdr_q  <= tdr_d;
      tcr_q  <= tcr_d;
      tsr_q  <= tsr_d;
      tcnt_q <= tcnt_d;
      tcr7_q <= tcr7_d;
      tap_q  <= tap_d;
    end
  end

  assign o_tdr  = tdr_q;
  assign o_tcr  = DATA_WIDTH'(tcr_q);
  assign o_tsr  = DATA_WIDTH'(tsr_q);
  assign o_tcnt = tcnt_q;
  assign o_ovf  = tsr_q[OVF];
  assign o_udf  = tsr_q[UDF];

endmodule
`default_nettype wire

// File: rtl/apb_timer_multi.sv
`default_nettype none
// ============================================================================
// apb_timer_multi : NUM_CH APB timer channels, shared prescaler (TIMER_AUTO_RELOAD_EN) | rev 1.0
// ============================================================================
module apb_timer_multi
  import timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [NUM_CH-1:0]     TMR_OVF,
  output logic [NUM_CH-1:0]     TMR_URF
);

  localparam int CH_W = ADDR_WIDTH - 2;

  logic [3:0] pre_q, pre_d;

  logic [CH_W-1:0]       w_ch;
  logic [1:0]            w_ofs;
  logic                  w_access;
  logic                  w_ch_valid;
  logic                  w_err;
  logic                  w_wr;
  logic                  w_rd;
  logic [NUM_CH-1:0]     w_hit;
  logic [DATA_WIDTH-1:0] w_ch_rd [NUM_CH];

  assign w_ch       = PADDR[ADDR_WIDTH-1:2];
  assign w_ofs      = PADDR[1:0];
  assign w_access   = PSEL & PENABLE;
  assign w_ch_valid = int'(w_ch) < NUM_CH;
  assign w_err      = w_access & (~w_ch_valid | (PWRITE & (w_ofs == TCNT_OFS)));
  assign w_wr       = w_access & PWRITE & ~w_err & ~PRESET;
  assign w_rd       = w_access & ~PWRITE & ~w_err & ~PRESET;

  assign PREADY  = 1'b1;
  assign PSLVERR = w_err & ~PRESET;

  assign pre_d = pre_q + 4'd1;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] w_tdr;
    logic [DATA_WIDTH-1:0] w_tcr;
    logic [DATA_WIDTH-1:0] w_tsr;
    logic [DATA_WIDTH-1:0] w_tcnt;

    assign w_hit[c] = (w_ch == CH_W'(c));

    timer_channel #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_ch (
      .clk      (PCLK),
      .rst      (PRESET),
      .i_pre    (pre_q),
      .i_wr_tdr (w_wr & w_hit[c] & (w_ofs == TDR_OFS)),
      .i_wr_tcr (w_wr & w_hit[c] & (w_ofs == TCR_OFS)),
      .i_wr_tsr (w_wr & w_hit[c] & (w_ofs == TSR_OFS)),
      .i_wdata  (PWDATA),
      .o_tdr    (w_tdr),
      .o_tcr    (w_tcr),
      .o_tsr    (w_tsr),
      .o_tcnt   (w_tcnt),
      .o_ovf    (TMR_OVF[c]),
      .o_udf    (TMR_URF[c])
    );

    assign w_ch_rd[c] = (w_ofs == TDR_OFS) ? w_tdr :
                        (w_ofs == TCR_OFS) ? w_tcr :
                        (w_ofs == TSR_OFS) ? w_tsr : w_tcnt;
  end

  always_comb begin
    PRDATA = '0;
    if (w_rd) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_hit[c]) PRDATA = w_ch_rd[c];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_timer_multi.sv
`default_nettype none
// ============================================================================
// tb_apb_timer_multi : self-checking bench for apb_timer_multi (TIMER_AUTO_RELOAD_EN aware) | rev 1.0
// ============================================================================
module tb_apb_timer_multi;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic [3:0] TMR_OVF;
  logic [3:0] TMR_URF;

  always #5 PCLK = ~PCLK;

  apb_timer_multi #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8),
    .NUM_CH     (4)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .TMR_OVF (TMR_OVF),
    .TMR_URF (TMR_URF)
  );

`ifdef TIMER_AUTO_RELOAD_EN
  localparam logic [7:0] EXP_TCR_6F = 8'h63;
  localparam logic [7:0] EXP_TCR_50 = 8'h50;
  localparam logic [7:0] EXP_AFTER_FF = 8'hF0;
`else
  localparam logic [7:0] EXP_TCR_6F = 8'h23;
  localparam logic [7:0] EXP_TCR_50 = 8'h10;
  localparam logic [7:0] EXP_AFTER_FF = 8'h00;
`endif

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic       wr;
    logic [7:0] rd;
    logic       err;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                              input logic [7:0] exp_rd, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rd = exp_rd; v.exp_err = exp_err;
    tbl.push_back(v);
  endfunction

  // One APB transfer; the expectation is queued at setup and retired at the access-phase sample.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                     input logic [7:0] exp_rd, input logic exp_err);
    exp_t e;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    e.addr = addr; e.wr = wr; e.rd = exp_rd; e.err = exp_err;
    exp_q.push_back(e);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    if (exp_q.size() == 0) begin
      check("scoreboard underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check($sformatf("%s 0x%02h PRDATA", e.wr ? "wr" : "rd", e.addr), PRDATA, e.rd);
      check($sformatf("%s 0x%02h PSLVERR", e.wr ? "wr" : "rd", e.addr), PSLVERR, e.err);
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic hold_read(input logic [7:0] addr);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
  endtask

  task automatic step();
    @(posedge PCLK); #2;
  endtask

  task automatic release_bus();
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
  endtask

  int t_a, t_b;
  bit seen_a, seen_b;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1;
    PRESET = 1'b0;

    check("reset PRDATA", PRDATA, 8'h00);
    check("reset PSLVERR", PSLVERR, 1'b0);
    check("reset PREADY", PREADY, 1'b1);
    check("reset TMR_OVF", TMR_OVF, 4'h0);
    check("reset TMR_URF", TMR_URF, 4'h0);

    // Reset arriving during an access phase must abort the write.
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 8'h77;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    apb(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

    // Register map and decode table.
    for (int a = 0; a < 16; a++) add(1'b0, 8'(a), 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h10, 8'h00, 8'h00, 1'b1);
    add(1'b1, 8'h04, 8'h5A, 8'h00, 1'b0);
    add(1'b1, 8'h05, 8'h80, 8'h00, 1'b0);
    add(1'b0, 8'h07, 8'h00, 8'h5A, 1'b0);
    add(1'b0, 8'h03, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h0B, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h0F, 8'h00, 8'h00, 1'b0);
    add(1'b1, 8'h07, 8'h33, 8'h00, 1'b1);
    add(1'b0, 8'h07, 8'h00, 8'h5A, 1'b0);
    add(1'b1, 8'h14, 8'hAA, 8'h00, 1'b1);
    add(1'b0, 8'h04, 8'h00, 8'h5A, 1'b0);
    add(1'b0, 8'h05, 8'h00, 8'h80, 1'b0);
    add(1'b1, 8'h05, 8'h6F, 8'h00, 1'b0);
    add(1'b0, 8'h05, 8'h00, EXP_TCR_6F, 1'b0);
    add(1'b1, 8'h05, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'h07, 8'h00, 8'h5A, 1'b0);
    add(1'b0, 8'h06, 8'h00, 8'h00, 1'b0);
    add(1'b0, 8'hFF, 8'h00, 8'h00, 1'b1);
    foreach (tbl[i]) apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);

    // ch0 up-count /2 through the overflow.
    apb(1'b1, 8'h00, 8'hFE, 8'h00, 1'b0);
    apb(1'b1, 8'h01, 8'h80, 8'h00, 1'b0);
    apb(1'b1, 8'h01, 8'h10, 8'h00, 1'b0);
    hold_read(8'h03);
    seen_a = 0; t_a = -1; t_b = -1;
    for (int i = 0; i < 40 && t_b < 0; i++) begin
      if (PRDATA == 8'hFF) begin
        if (!seen_a) check("ch0 OVF before wrap", TMR_OVF[0], 1'b0);
        seen_a = 1;
      end else if (PRDATA == 8'h00 && seen_a && t_a < 0) begin
        t_a = i;
        check("ch0 OVF on wrap edge", TMR_OVF[0], 1'b1);
      end else if (PRDATA == 8'h01 && t_a >= 0) begin
        t_b = i;
      end
      step();
    end
    release_bus();
    check("ch0 reached 0xFF", seen_a, 1'b1);
    check("ch0 /2 period after wrap", t_b - t_a, 32'd2);
    apb(1'b1, 8'h02, 8'h01, 8'h00, 1'b0);
    check("ch0 OVF W1C", TMR_OVF[0], 1'b0);
    apb(1'b1, 8'h01, 8'h00, 8'h00, 1'b0);

    // ch2 down-count /16 through the underflow.
    apb(1'b1, 8'h08, 8'h01, 8'h00, 1'b0);
    apb(1'b1, 8'h09, 8'h80, 8'h00, 1'b0);
    apb(1'b1, 8'h09, 8'h33, 8'h00, 1'b0);
    hold_read(8'h0B);
    seen_a = 0; seen_b = 0; t_a = -1; t_b = -1;
    for (int i = 0; i < 70 && t_b < 0; i++) begin
      if (PRDATA == 8'h00) begin
        seen_a = 1;
        if (TMR_URF[2]) seen_b = 1;
      end else if (PRDATA == 8'hFF && t_a < 0) begin
        t_a = i;
        check("ch2 URF on wrap edge", TMR_URF[2], 1'b1);
      end else if (PRDATA == 8'hFE && t_a >= 0) begin
        t_b = i;
      end
      step();
    end
    release_bus();
    check("ch2 passed through 0x00", seen_a, 1'b1);
    check("ch2 URF clear at 0x00", seen_b, 1'b0);
    check("ch2 reached 0xFF", (t_a >= 0 && t_a <= 34), 1'b1);
    check("ch2 /16 period", t_b - t_a, 32'd16);
    apb(1'b1, 8'h0A, 8'h00, 8'h00, 1'b0);
    check("ch2 URF after W1C of 0", TMR_URF[2], 1'b1);
    apb(1'b0, 8'h0A, 8'h00, 8'h02, 1'b0);
    apb(1'b1, 8'h09, 8'h00, 8'h00, 1'b0);

    // Load vs tick: three phase offsets guarantee one coincident case at /2.
    apb(1'b1, 8'h00, 8'h40, 8'h00, 1'b0);
    for (int k = 0; k < 3; k++) begin
      apb(1'b1, 8'h01, 8'h10, 8'h00, 1'b0);
      idle(k + 1);
      apb(1'b1, 8'h01, 8'h90, 8'h00, 1'b0);
      apb(1'b0, 8'h03, 8'h00, 8'h40, 1'b0);
    end

    // Flag set vs W1C on the same edge, again over three phase offsets.
    for (int k = 0; k < 3; k++) begin
      apb(1'b1, 8'h01, 8'h00, 8'h00, 1'b0);
      apb(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0);
      apb(1'b1, 8'h02, 8'h01, 8'h00, 1'b0);
      check($sformatf("ch0 OVF cleared k=%0d", k), TMR_OVF[0], 1'b0);
      idle(k + 1);
      apb(1'b1, 8'h01, 8'h90, 8'h00, 1'b0);
      apb(1'b1, 8'h02, 8'h01, 8'h00, 1'b0);
      idle(2);
      check($sformatf("ch0 OVF beats W1C k=%0d", k), TMR_OVF[0], 1'b1);
    end
    apb(1'b1, 8'h01, 8'h00, 8'h00, 1'b0);

    // ch3 auto-reload (or plain wrap when the feature is absent).
    apb(1'b1, 8'h0C, 8'hF0, 8'h00, 1'b0);
    apb(1'b1, 8'h0D, 8'h50, 8'h00, 1'b0);
    apb(1'b0, 8'h0D, 8'h00, EXP_TCR_50, 1'b0);
    hold_read(8'h0F);
    seen_a = 0; seen_b = 0;
    for (int i = 0; i < 700 && !seen_b; i++) begin
      if (PRDATA == 8'hFF) begin
        if (!seen_a) check("ch3 OVF before wrap", TMR_OVF[3], 1'b0);
        seen_a = 1;
      end else if (seen_a) begin
        seen_b = 1;
        check("ch3 value after 0xFF", PRDATA, EXP_AFTER_FF);
        check("ch3 OVF on wrap edge", TMR_OVF[3], 1'b1);
      end
      step();
    end
    release_bus();
    check("ch3 wrap observed", seen_b, 1'b1);
    check("scoreboard drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_timer_multi.md
Name: apb_timer_multi

Overview:
- Parametrised successor to the single 8-bit APB timer: NUM_CH independent up/down timer channels, each DATA_WIDTH bits wide, behind one APB slave.
- Channels share one free-running prescaler.
- Each channel has the TDR/TCR/TSR/TCNT register set, sticky overflow/underflow status with write-1-to-clear, and per-channel flag outputs.
- Sits on the peripheral APB bus; flags go to the interrupt controller.

Parameters:
- ADDR_WIDTH, 8, APB address width; must satisfy 4*NUM_CH <= 2**ADDR_WIDTH.
- DATA_WIDTH, 8, APB data width and counter width; must be >= 8.
- NUM_CH, 4, number of timer channels, 1..64.

Ports:
- PCLK  in  1  sole clock.
- PRESET  in  1  synchronous reset, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  ADDR_WIDTH  byte address.
- PWDATA  in  DATA_WIDTH  write data.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  always 1; no wait states.
- PSLVERR  out  1  error response.
- TMR_OVF  out  NUM_CH  per-channel sticky overflow flag (mirror of TSR[0]).
- TMR_URF  out  NUM_CH  per-channel sticky underflow flag (mirror of TSR[1]).

Behaviour:
- Address map: channel c = PADDR[ADDR_WIDTH-1:2], offset = PADDR[1:0].
  - Offset 0: TDR, RW.
  - Offset 1: TCR, RW.
  - Offset 2: TSR, read / W1C.
  - Offset 3: TCNT, RO.
- TCR bit fields (upper bits read 0):
  - [7] Load.
  - [5] Up/Dw, 1 = down.
  - [4] En.
  - [1:0] Cks.
- TSR bit fields: [0] OVF, [1] UDF; other bits read 0.
- Reset (PRESET high at a PCLK edge):
  - All TDR/TCR/TSR/TCNT cleared; prescaler cleared; edge-detect flops cleared.
  - PRDATA = 0, PSLVERR = 0, TMR_OVF = 0, TMR_URF = 0; PREADY = 1.
  - Reset mid-transfer aborts the transfer with no register update.
- APB access phase = PSEL & PENABLE.
  - Writes commit at the PCLK edge ending the access phase.
  - PRDATA is combinational during a read access phase and 0 otherwise.
- PSLVERR is asserted combinationally in the access phase when:
  - c >= NUM_CH, or
  - the access is a write to TCNT.
  - An erroring write changes nothing; an erroring read returns 0.
- TSR write: each PWDATA bit that is 1 clears the matching flag; 0 bits have no effect.
- Prescaler: a free-running counter pre[3:0], incremented every cycle.
  - Selected bit per Cks: 00 = pre[0] (/2), 01 = pre[1] (/4), 10 = pre[2] (/8), 11 = pre[3] (/16).
  - Channel tick = selected bit high & registered copy low, i.e. the rising edge, detected per channel.
  - A Cks change may cause one extra or missing tick; this is permitted.
- Load: load_pulse = TCR[7] & ~tcr7_q.
  - TCNT <= TDR at the edge after the TCR write that sets bit 7, so TCNT is updated 1 cycle after the write completes.
  - Load uses the current TDR contents.
- Count, on a tick with En = 1 and no load_pulse:
  - Up: TCNT + 1. At all-ones it wraps to 0 and OVF is set on the same edge.
  - Down: TCNT - 1. At 0 it wraps to all-ones and UDF is set on the same edge.
- Priority:
  - Load beats tick in the same cycle.
  - Flag set beats a W1C of the same bit in the same cycle.
  - Channels are fully independent.

Optional Feature:
- Macro: TIMER_AUTO_RELOAD_EN.
- Defined: TCR[6] = ARE, RW.
  - When ARE = 1, an overflow or underflow reloads TCNT from TDR instead of wrapping.
  - The OVF/UDF flag is still set.
- Undefined: TCR[6] reads 0, writes are ignored, and counting always wraps.

Decomposition:
- Package timer_pkg holds:
  - Offset constants TDR_OFS = 0, TCR_OFS = 1, TSR_OFS = 2, TCNT_OFS = 3.
  - TCR bit indices LOAD = 7, ARE = 6, UPDW = 5, EN = 4, CKS = [1:0].
  - TSR bit indices OVF = 0, UDF = 1.
  - Cks encodings.
- Sub-module timer_channel (generated NUM_CH times) holds:
  - Registers TDR/TCR/TSR/TCNT.
  - Load and tick edge detection.
  - The counter.
- The top level holds the APB decode, read mux, PSLVERR logic and prescaler.

Test Plan:
1. Reset, then read all 16 addresses (NUM_CH = 4) -> all 0x00, PSLVERR = 0; read 0x10 -> PSLVERR = 1, PRDATA = 0x00.
2. Write TDR ch1 (0x04) = 0x5A, TCR ch1 (0x05) = 0x80 -> TCNT ch1 (0x07) reads 0x5A; ch0/ch2/ch3 TCNT stay 0x00; write 0x07 -> PSLVERR = 1 and TCNT unchanged.
3. ch0: TDR = 0xFE, load, TCR = 0x10 (up, Cks = 00) -> TCNT reaches 0xFF, then 0x00 with TMR_OVF[0] = 1; write TSR(0x02) = 0x01 -> TMR_OVF[0] = 0.
4. ch2: TDR = 0x01, load, TCR = 0x33 (down, /16) -> TCNT = 0x00 after 16 cycles and 0xFF after 32, with TMR_URF[2] = 1; writing TSR 0x00 leaves the flag set.
5. Same-cycle priority: force a tick coincident with load_pulse -> TCNT = TDR; force an OVF on the same edge as W1C of OVF -> flag stays 1.
6. With TIMER_AUTO_RELOAD_EN: ch3 TDR = 0xF0, TCR = 0x50 -> after 0xFF, TCNT = 0xF0 and TMR_OVF[3] = 1. Without the macro, TCR reads back 0x10 after the same write.
